// File: rtl/tinyriscv_pkg.sv
// Shared tinyriscv types and widths, including the memory-copy engine's state
// encoding and default word-count width.
package tinyriscv_pkg;

  localparam int MemAddrBus = 32;
  localparam int MemBus = 32;
  localparam logic WriteEnable = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam int DmaLenW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/ram_dma.sv
// Word-granular forward memory copy on the single-port data-RAM interface:
// one read then one write per word, ascending addresses, done/err pulse at the end.
module ram_dma
  import tinyriscv_pkg::*;
#(
  parameter int LenW = DmaLenW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [MemAddrBus-1:0] src_addr_i,
  input  logic [MemAddrBus-1:0] dst_addr_i,
  input  logic [LenW-1:0]       len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [MemAddrBus-1:0] mem_addr_o,
  output logic [MemBus-1:0]     mem_wdata_o,
  input  logic [MemBus-1:0]     mem_rdata_i,
  output dma_state_e            state_o
);

  // Handshake: mem_req_o is held with address/we/wdata stable until an edge
  // where mem_gnt_i is also high; that edge completes the access (read data
  // is captured, or the write is committed) and only then do outputs move on.

  localparam logic [MemAddrBus-1:0] WordStep = MemAddrBus'(4);

  dma_state_e            state_q, state_d;
  logic [MemAddrBus-1:0] cur_src_q, cur_dst_q;
  logic [LenW-1:0]       remaining_q;
  logic [MemBus-1:0]     buf_q;
  logic                  err_q;
  logic                  start_bad;

  assign start_bad = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);
  assign state_o   = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cur_src_q   <= '0;
      cur_dst_q   <= '0;
      remaining_q <= '0;
      buf_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cur_src_q   <= src_addr_i;
            cur_dst_q   <= dst_addr_i;
            remaining_q <= len_i;
            err_q       <= start_bad;
          end
        end
        READ: begin
          if (mem_gnt_i) begin
            buf_q     <= mem_rdata_i;
            cur_src_q <= cur_src_q + WordStep;
          end
        end
        WRITE: begin
          if (mem_gnt_i) begin
            cur_dst_q   <= cur_dst_q + WordStep;
            remaining_q <= remaining_q - LenW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs depend only on state and registers, so an async reset zeroes them at once.
  always_comb begin
    state_d     = state_q;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    err_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = WriteDisable;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          if (start_bad || (len_i == '0)) state_d = DONE;
          else                            state_d = READ;
        end
      end
      READ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = cur_src_q;
        if (mem_gnt_i) state_d = WRITE;
      end
      WRITE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = WriteEnable;
        mem_addr_o  = cur_dst_q;
        mem_wdata_o = buf_q;
        // remaining_q is the count before this write retires
        if (mem_gnt_i) state_d = (remaining_q == LenW'(1)) ? DONE : READ;
      end
      DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_dma.sv
// Randomized bench for ram_dma: a behavioural RAM plus a forward-copy reference
// model predicting every memory access, the final RAM image and done timing.
module tb_ram_dma;
  import tinyriscv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] src_addr_i = '0;
  logic [31:0] dst_addr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, err_o, mem_req_o, mem_we_o;
  logic        mem_gnt_i = 1'b0;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  dma_state_e  state_o;

  logic [31:0] ram [0:255];
  logic [31:0] shadow [0:255];
  logic [64:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  ram_dma #(.LenW(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  assign mem_rdata_i = ram[mem_addr_o[9:2]];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: a plain sequential word copy over the shadow image, logging each access.
  task automatic model_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    logic [31:0] a, d, w;
    for (int k = 0; k < len; k++) begin
      a = src + 32'(4 * k);
      w = dst + 32'(4 * k);
      d = shadow[a[9:2]];
      exp_q.push_back({1'b0, a, d});
      exp_q.push_back({1'b1, w, d});
      shadow[w[9:2]] = d;
    end
  endtask

  task automatic check_image(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== shadow[i]) bad++;
    check_eq(tag, bad, 0);
  endtask

  // scoreboard: RAM behaviour plus access-by-access comparison
  always @(posedge clk_i) begin
    logic [64:0] e;
    if (!rst_i && mem_req_o && mem_gnt_i) begin
      if (mem_we_o) begin
        ram[mem_addr_o[9:2]] = mem_wdata_o;
        wr_cnt++;
      end else begin
        rd_cnt++;
      end
      if (exp_q.size() == 0) begin
        check_eq("unexpected_access", mem_addr_o, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("acc_we", {31'b0, mem_we_o}, {31'b0, e[64]});
        check_eq("acc_addr", mem_addr_o, e[63:32]);
        if (mem_we_o) check_eq("acc_wdata", mem_wdata_o, e[31:0]);
      end
    end
  end

  // driver: one start, grant pattern, and end-of-transfer checks
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int gnt_pct, input int stall_at, input int stall_len,
                          input bit restart, output int done_cyc);
    int cyc = 0;
    int stalls = 0;
    int busy_low = 0;
    int exp_cyc;
    bit exp_err, gnt, prev_wstall;
    logic err_seen = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    exp_err = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
    if (!exp_err) model_copy(src, dst, len);
    rd_cnt = 0;
    wr_cnt = 0;
    prev_wstall = 1'b0;
    done_cyc = -1;
    @(negedge clk_i);
    start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = 16'(len); mem_gnt_i = 1'b0;
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clk_i);
      cyc++;
      start_i = 1'b0;
      if (restart && cyc == 3) begin
        start_i = 1'b1; src_addr_i = 32'h40; dst_addr_i = 32'h80; len_i = 16'd2;
      end
      if (!busy_o) busy_low++;
      if (prev_wstall) begin
        check_eq("stall_we", {31'b0, mem_we_o}, 32'd1);
        check_eq("stall_addr", mem_addr_o, prev_addr);
        check_eq("stall_wdata", mem_wdata_o, prev_wdata);
      end
      if (done_o) begin
        done_cyc = cyc;
        err_seen = err_o;
      end
      gnt = ($urandom_range(0, 99) < gnt_pct);
      if (cyc >= stall_at && cyc < stall_at + stall_len) gnt = 1'b0;
      mem_gnt_i = gnt;
      prev_wstall = mem_req_o && mem_we_o && !gnt;
      prev_addr = mem_addr_o;
      prev_wdata = mem_wdata_o;
      if (mem_req_o && !gnt) stalls++;
    end
    exp_cyc = (exp_err || len == 0) ? 1 : 2 * len + 1 + stalls;
    check_eq("done_cycle", done_cyc, exp_cyc);
    check_eq("err", {31'b0, err_seen}, {31'b0, exp_err});
    check_eq("busy_low_cycles", busy_low, 0);
    check_eq("reads", rd_cnt, exp_err ? 0 : len);
    check_eq("writes", wr_cnt, exp_err ? 0 : len);
    check_eq("exp_q_left", exp_q.size(), 0);
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    check_eq("done_single", {31'b0, done_o}, 32'd0);
    check_eq("idle_busy", {31'b0, busy_o}, 32'd0);
    check_image("mem_image");
  endtask

  initial begin
    int dc;
    logic [31:0] s, d;
    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom;
      shadow[i] = ram[i];
    end
    for (int k = 0; k < 4; k++) begin
      ram[64 + k] = 32'h1111_1111 * 32'(k + 1);
      shadow[64 + k] = ram[64 + k];
    end
    #1;
    check_eq("rst_outputs", {busy_o, done_o, err_o, mem_req_o, mem_we_o},  5'b0);
    check_eq("rst_addr", mem_addr_o, 32'h0);
    check_eq("rst_wdata", mem_wdata_o, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // 4-word copy with continuous grant
    run_copy(32'h100, 32'h200, 4, 100, 0, 0, 1'b0, dc);
    check_eq("copy4_done_cyc", dc, 9);
    for (int k = 0; k < 4; k++)
      check_eq("copy4_word", ram[128 + k], 32'h1111_1111 * 32'(k + 1));

    // len = 0 and misaligned starts
    run_copy(32'h100, 32'h200, 0, 100, 0, 0, 1'b0, dc);
    check_eq("len0_done_cyc", dc, 1);
    run_copy(32'h102, 32'h200, 3, 100, 0, 0, 1'b0, dc);
    check_eq("misalign_done_cyc", dc, 1);

    // grant withheld 3 cycles during first WRITE of a 2-word copy
    run_copy(32'h180, 32'h280, 2, 100, 2, 3, 1'b0, dc);
    check_eq("stall_done_cyc", dc, 8);

    // start pulsed mid-transfer is ignored
    run_copy(32'h0c0, 32'h2c0, 4, 100, 0, 0, 1'b1, dc);
    check_eq("restart_done_cyc", dc, 9);

    // overlapping forward copy re-reads overwritten words
    run_copy(32'h100, 32'h104, 4, 70, 0, 0, 1'b0, dc);

    // random transfers with random grant
    for (int t = 0; t < 8; t++) begin
      s = 32'($urandom_range(0, 191)) * 4;
      d = 32'($urandom_range(0, 191)) * 4;
      if (t == 7) s[1:0] = 2'(1 + $urandom_range(0, 2));
      run_copy(s, d, $urandom_range(0, 8), 60, 0, 0, 1'b0, dc);
    end

    // async reset during WRITE of word 2 of 5
    model_copy(32'h140, 32'h340, 2);
    exp_q.push_back({1'b0, 32'h148, shadow[8'h52]});
    @(negedge clk_i);
    start_i = 1'b1; src_addr_i = 32'h140; dst_addr_i = 32'h340; len_i = 16'd5; mem_gnt_i = 1'b1;
    repeat (6) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    check_eq("pre_rst_we", {31'b0, mem_we_o}, 32'd1);
    check_eq("pre_rst_addr", mem_addr_o, 32'h348);
    #1 rst_i = 1'b1;
    #1;
    check_eq("async_rst_outputs", {27'b0, busy_o, done_o, err_o, mem_req_o, mem_we_o}, 32'd0);
    check_eq("async_rst_addr", mem_addr_o, 32'h0);
    check_eq("async_rst_wdata", mem_wdata_o, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_no_done", {31'b0, done_o}, 32'd0);
    mem_gnt_i = 1'b0;
    rst_i = 1'b0;
    check_eq("rst_exp_q_left", exp_q.size(), 0);
    check_image("rst_mem_image");
    repeat (2) begin
      @(negedge clk_i);
      check_eq("post_rst_no_done", {31'b0, done_o}, 32'd0);
    end
    run_copy(32'h140, 32'h340, 5, 100, 0, 0, 1'b0, dc);
    check_eq("post_rst_done_cyc", dc, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
